// File: rtl/opendap_ap_access_ctrl_if.sv
// APB-style AP bus between the DP access controller and the AP interconnect.
//
// Signals:
//   paddr    16  {APSEL, {APBANKSEL, A[3:2], 2'b00}}
//   psel     1   transfer selected (SETUP and ACCESS phases)
//   penable  1   ACCESS phase
//   pwrite   1   1 = write, 0 = read
//   pwdata   32  write data
//   prdata   32  read data from the AP
//   pready   1   AP completes the ACCESS phase
//   pslverr  1   AP reports an error with the completion
//
// Modports: master (access controller side), slave (AP side).
interface opendap_ap_access_ctrl_if;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/opendap_ap_access_ctrl.sv
// AP access sequencer for the SW-DP. Takes one AP access request at a time
// from the DP register core, runs it as an APB SETUP/ACCESS transfer, captures
// read data into RDBUFF and pulses set_stickyerr on slave error or timeout.
//
// Parameters:
//   TIMEOUT        max ACCESS-phase cycles before forced termination (0 = never)
//
// Ports:
//   swclk          SWD clock, all state on posedge
//   rst_n          asynchronous active-low reset
//   req_en         single-cycle AP access strobe
//   req_r_nw       1 = read, 0 = write
//   req_apsel      SELECT.APSEL
//   req_addr       {SELECT.APBANKSEL, A[3:2], 2'b00}
//   req_wdata      write data
//   abort          ABORT.DAPABORT strobe
//   busy           transfer in flight (DP answers WAIT while high)
//   rdbuff         data from the last successful read
//   set_stickyerr  one-cycle pulse setting CTRL/STAT.STICKYERR
//   apb            APB master port (paddr/psel/penable/pwrite/pwdata out,
//                  prdata/pready/pslverr in)
module opendap_ap_access_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                            swclk,
    input  logic                            rst_n,
    input  logic                            req_en,
    input  logic                            req_r_nw,
    input  logic [7:0]                      req_apsel,
    input  logic [7:0]                      req_addr,
    input  logic [31:0]                     req_wdata,
    input  logic                            abort,
    output logic                            busy,
    output logic [31:0]                     rdbuff,
    output logic                            set_stickyerr,
    opendap_ap_access_ctrl_if.master        apb
);

    localparam bit          TimeoutEn   = (TIMEOUT != 0);
    // Last counter value before expiry; unused when the timeout is disabled.
    localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT - 1) : 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } state_e;

    state_e      state_q;
    logic [15:0] tmo_cnt_q;
    logic [15:0] paddr_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [31:0] rdbuff_q;
    logic        sticky_q;

    logic        tmo_hit;
    assign tmo_hit = TimeoutEn && (tmo_cnt_q == TimeoutLast);

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tmo_cnt_q <= 16'h0000;
            paddr_q   <= 16'h0000;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'h0000_0000;
            rdbuff_q  <= 32'h0000_0000;
            sticky_q  <= 1'b0;
        end else begin
            sticky_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // An abort in the same cycle as a request drops the request.
                    if (req_en && !abort) begin
                        state_q   <= StSetup;
                        paddr_q   <= {req_apsel, req_addr};
                        pwrite_q  <= !req_r_nw;
                        if (!req_r_nw) begin
                            pwdata_q <= req_wdata;
                        end
                        tmo_cnt_q <= 16'h0000;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end

                StSetup: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end else begin
                        state_q   <= StAccess;
                        penable_q <= 1'b1;
                    end
                end

                StAccess: begin
                    // Completion takes priority over both timeout and abort.
                    if (apb.pready) begin
                        state_q   <= StIdle;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (apb.pslverr) begin
                            sticky_q <= 1'b1;
                        end else if (!pwrite_q) begin
                            rdbuff_q <= apb.prdata;
                        end
                    end else if (tmo_hit) begin
                        state_q   <= StIdle;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        sticky_q  <= 1'b1;
                    end else if (abort) begin
                        state_q   <= StIdle;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end else if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_q <= tmo_cnt_q + 16'h0001;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (state_q != StIdle);
    assign rdbuff        = rdbuff_q;
    assign set_stickyerr = sticky_q;

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;

endmodule

// File: doc/opendap_ap_access_ctrl.md
# opendap_ap_access_ctrl

Sequences AP accesses requested by the SW-DP core onto an APB-style AP bus, one transfer at a time. It latches the access parameters, runs the SETUP/ACCESS phases, captures read data into RDBUFF and raises sticky errors. Its `busy` output feeds the DP's WAIT decision. It sits between the DP register core (downstream of the SWD serial comms) and the AP interconnect. Everything runs in the swclk domain.

## Interface
- TIMEOUT, default 1024: maximum ACCESS-phase cycles before forced termination. 0 disables; legal range 0..65535.
- swclk  in  1  SWD clock; all state on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_en  in  1  single-cycle AP access strobe from the DP core.
- req_r_nw  in  1  1 = read, 0 = write.
- req_apsel  in  8  SELECT.APSEL.
- req_addr  in  8  {SELECT.APBANKSEL, A[3:2], 2'b00}.
- req_wdata  in  32  write data.
- abort  in  1  ABORT.DAPABORT strobe.
- busy  out  1  transfer in flight; DP returns WAIT to AP accesses while high.
- rdbuff  out  32  data from the last successful read.
- set_stickyerr  out  1  one-cycle pulse that sets CTRL/STAT.STICKYERR.
- paddr  out  16  {apsel, addr}.
- psel, penable, pwrite  out  1  APB controls.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready, pslverr  in  1  APB completion and error.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- IDLE → SETUP on req_en && !abort:
  - latch paddr, pwrite=!req_r_nw, pwdata (write only; pwdata holds its old value on reads).
  - clear timeout counter.
- SETUP → ACCESS unconditionally, unless abort is high; then → IDLE.
- ACCESS, pready=1:
  - → IDLE.
  - if pslverr: pulse set_stickyerr; rdbuff unchanged.
  - else if read: rdbuff ← prdata.
- ACCESS, pready=0, counter == TIMEOUT-1 (TIMEOUT≠0): → IDLE, pulse set_stickyerr, rdbuff unchanged.
- ACCESS, pready=0, abort=1: → IDLE, no sticky, rdbuff unchanged.
- Otherwise ACCESS holds and the counter increments (16-bit, saturating).
- busy = (state != IDLE), decoded from registered state.
- Simultaneous events:
  - req_en while busy: ignored. The DP guarantees this never happens; the bench asserts on it.
  - pready and abort in the same ACCESS cycle: completion wins (rdbuff/sticky update as normal).
  - abort and req_en in IDLE: request dropped.
  - pready and timeout expiry in the same cycle: completion wins.
- Outputs in IDLE: psel=0, penable=0. paddr, pwrite and pwdata hold their last values.
- Async reset mid-transfer: immediate return to IDLE; every output takes its reset value; the APB slave sees psel drop.

## Timing
- Reset values: busy 0, psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, rdbuff 0, set_stickyerr 0.
- All outputs are registered or decoded from registered state.
- Zero-wait transfer, req_en sampled at edge N:
  - psel=1 after N.
  - penable=1 after N+1.
  - pready sampled at edge N+2.
  - rdbuff/set_stickyerr valid and busy=0 after N+2.
- busy is high for exactly 2 cycles plus one per wait state.
- set_stickyerr is high for exactly one cycle.
- Back-to-back: a new req_en is accepted in the first cycle busy=0.

## Test plan
- Read, apsel=0x00, addr=0xFC, prdata=0x24770011, zero wait → psel for 2 cycles, penable on cycle 2, rdbuff=0x24770011 on cycle 3, busy high exactly 2 cycles.
- Write, apsel=0x01, addr=0x04, wdata=0xDEADBEEF, 3 wait states → paddr=0x0104, pwrite=1, pwdata stable throughout, busy 5 cycles, no set_stickyerr.
- Read with pslverr=1 at completion → single set_stickyerr pulse; rdbuff keeps its prior value 0x24770011.
- TIMEOUT=8, pready stuck low → ACCESS lasts 8 cycles, then psel=0, set_stickyerr pulse, busy=0; a next read completes normally.
- abort in ACCESS with pready=0 → IDLE next cycle, no sticky; abort coincident with pready=1 → rdbuff updated.
- Reset asserted during ACCESS → psel, penable, busy and rdbuff read 0 immediately; the FSM accepts a new request after release.
